// File: rtl/ltc2333_read.sv
// LTC2333 SDO capture engine: deserialises 24-bit conversion records into a
// small FIFO presented as a valid/ready stream, with sticky error flags.
module ltc2333_read #(
  parameter int MAX_WORDS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CHECK_CHAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [3:0]  n_words,
  input  logic [2:0]  exp_chan,
  input  logic        sdo,
  input  logic        clr_err,
  output logic [17:0] out_result,
  output logic [2:0]  out_chan,
  output logic [2:0]  out_span,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        word_done,
  output logic        frame_done,
  output logic        overflow,
  output logic        frame_err,
  output logic        chan_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  n_lat, n_lat_next;
  logic [3:0]  word_cnt, word_cnt_next;
  logic [4:0]  bit_cnt, bit_cnt_next;
  logic [22:0] shreg;
  logic [3:0]  n_clamped;
  logic [23:0] push_word;
  logic        push;
  logic        restart;
  logic        chan_bad;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_ok;
  logic [23:0]   head;

  assign n_clamped = (n_words > 4'(MAX_WORDS)) ? 4'(MAX_WORDS) : n_words;
  assign push_word = {shreg, sdo};
  assign restart   = (state == SHIFT) && frame_start;
  assign chan_bad  = push && (CHECK_CHAN != 0) && (push_word[5:3] != exp_chan);

  always_comb begin
    state_next    = state;
    n_lat_next    = n_lat;
    word_cnt_next = word_cnt;
    bit_cnt_next  = bit_cnt;
    push          = 1'b0;
    case (state)
      IDLE, SHIFT: begin
        if (frame_start) begin
          // A start inside SHIFT abandons the partial word and reframes.
          n_lat_next    = n_clamped;
          word_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = (n_clamped == 4'd0) ? DONE : SHIFT;
        end else if (state == SHIFT) begin
          bit_cnt_next = bit_cnt + 5'd1;
          if (bit_cnt == 5'd23) begin
            push          = 1'b1;
            bit_cnt_next  = '0;
            word_cnt_next = word_cnt + 4'd1;
            if (word_cnt + 4'd1 == n_lat) state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n_lat      <= '0;
      word_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      n_lat      <= n_lat_next;
      word_cnt   <= word_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shreg      <= {shreg[21:0], sdo};
      word_done  <= push;
      frame_done <= (state == DONE);
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop     = out_valid && out_ready;
  assign push_ok = push && (!full || pop);

  // Storage needs no reset; outputs are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: an event in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      chan_err  <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clr_err) || (push && full && !pop);
      frame_err <= (frame_err && !clr_err) || restart;
      chan_err  <= (chan_err  && !clr_err) || chan_bad;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head[23:6] : '0;
  assign out_chan   = out_valid ? head[5:3]  : '0;
  assign out_span   = out_valid ? head[2:0]  : '0;
  assign busy       = (state == SHIFT);

endmodule

// File: tb/tb_ltc2333_read.sv
// Directed bench for ltc2333_read: a scoreboard queue is filled as frames are
// issued and a negedge monitor compares every word the DUT hands over.
module tb_ltc2333_read;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [3:0]  n_words = '0;
  logic [2:0]  exp_chan = '0;
  logic        sdo = 1'b0;
  logic        clr_err = 1'b0;
  logic [17:0] out_result;
  logic [2:0]  out_chan;
  logic [2:0]  out_span;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        word_done;
  logic        frame_done;
  logic        overflow;
  logic        frame_err;
  logic        chan_err;

  int n_vectors = 0;
  int n_miscompares = 0;
  int busy_cycles = 0;
  logic [23:0] exp_q[$];

  ltc2333_read #(.MAX_WORDS(8), .FIFO_DEPTH(4), .CHECK_CHAN(1)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .n_words(n_words),
    .exp_chan(exp_chan), .sdo(sdo), .clr_err(clr_err),
    .out_result(out_result), .out_chan(out_chan), .out_span(out_span),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .word_done(word_done), .frame_done(frame_done), .overflow(overflow),
    .frame_err(frame_err), .chan_err(chan_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: each negedge with valid&ready is one accepted head entry.
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL unexpected_word: got 0x%06h expected none",
                 {out_result, out_chan, out_span});
      end else begin
        check_output("fifo_word", {8'h0, out_result, out_chan, out_span},
                     {8'h0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [23:0] mk_word(input logic [17:0] r, input logic [2:0] c,
                                          input logic [2:0] s);
    return {r, c, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] n);
    frame_start = 1'b1;
    n_words = n;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [23:0] w, input int nbits,
                                input logic [2:0] ec, input bit ready_last);
    exp_chan = ec;
    for (int k = 0; k < nbits; k++) begin
      sdo = w[23-k];
      if (ready_last && k == 23) out_ready = 1'b1;
      tick();
      if (ready_last && k == 23) out_ready = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    check_output({name, "_drained"}, exp_q.size(), 0);
    tick();
    check_output({name, "_empty"}, out_valid, 0);
  endtask

  initial begin
    logic [23:0] w;
    logic [23:0] words[8];
    bit seen_done;
    int pushes;

    repeat (3) tick();
    reset = 1'b0;
    check_output("rst_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_flags", {word_done, frame_done, overflow, frame_err, chan_err}, 0);
    check_output("rst_data", {out_result, out_chan, out_span}, 0);

    // Single word 0xABCDE5.
    out_ready = 1'b1;
    busy_cycles = 0;
    exp_q.push_back(24'hABCDE5);
    start_frame(4'd1);
    apply_stimulus(24'hABCDE5, 24, 3'd4, 1'b0);
    check_output("single_word_done", word_done, 1);
    check_output("single_valid", out_valid, 1);
    check_output("single_result", out_result, 18'h2AF37);
    check_output("single_chan", out_chan, 3'd4);
    check_output("single_span", out_span, 3'd5);
    check_output("single_frame_done_early", frame_done, 0);
    tick();
    check_output("single_frame_done", frame_done, 1);
    check_output("single_word_done_off", word_done, 0);
    tick();
    check_output("single_busy_cycles", busy_cycles, 24);
    check_output("single_frame_done_off", frame_done, 0);

    // Full frame, channel IDs tracked.
    for (int i = 0; i < 8; i++) words[i] = mk_word(18'(32'h100 * i + 32'h3A5), 3'(i), 3'(7 - i));
    for (int i = 0; i < 8; i++) exp_q.push_back(words[i]);
    start_frame(4'd8);
    for (int i = 0; i < 8; i++) apply_stimulus(words[i], 24, 3'(i), 1'b0);
    tick(); tick();
    check_output("full_chan_err", chan_err, 0);
    check_output("full_qempty", exp_q.size(), 0);

    // Word 3 carries chan 5 while expecting 3.
    words[3] = mk_word(18'h3FFFF, 3'd5, 3'd2);
    for (int i = 0; i < 8; i++) exp_q.push_back(words[i]);
    start_frame(4'd8);
    for (int i = 0; i < 8; i++) apply_stimulus(words[i], 24, 3'(i), 1'b0);
    tick(); tick();
    check_output("mismatch_chan_err", chan_err, 1);
    check_output("mismatch_qempty", exp_q.size(), 0);
    pulse_clr();
    check_output("mismatch_clr", chan_err, 0);

    // Overflow: six words into a four-deep FIFO, no consumer.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = mk_word(18'(32'h20000 + i), 3'(i), 3'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
    start_frame(4'd6);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(words[i], 24, 3'(i), 1'b0);
      if (i == 3) check_output("ovf_after_4th", overflow, 0);
      if (i == 4) check_output("ovf_after_5th", overflow, 1);
    end
    tick(); tick();
    pulse_clr();
    check_output("ovf_clr", overflow, 0);
    drain("ovf");

    // Full FIFO with push and pop in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) words[i] = mk_word(18'(32'h15555 + 32'h11 * i), 3'd7, 3'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back(words[i]);
    start_frame(4'd4);
    for (int i = 0; i < 4; i++) apply_stimulus(words[i], 24, 3'd7, 1'b0);
    tick(); tick();
    start_frame(4'd1);
    apply_stimulus(words[4], 24, 3'd7, 1'b1);
    check_output("fullpop_overflow", overflow, 0);
    check_output("fullpop_head", {out_result, out_chan, out_span}, words[1]);
    tick(); tick();
    drain("fullpop");

    // Restart at bit 10 of word 1.
    out_ready = 1'b1;
    words[0] = 24'h123456;
    words[1] = 24'hFEDCBA;
    words[2] = 24'h5A5A5A;
    exp_q.push_back(words[0]);
    exp_q.push_back(words[2]);
    start_frame(4'd3);
    apply_stimulus(words[0], 24, words[0][5:3], 1'b0);
    apply_stimulus(words[1], 10, words[1][5:3], 1'b0);
    start_frame(4'd1);
    apply_stimulus(words[2], 24, words[2][5:3], 1'b0);
    tick(); tick();
    check_output("restart_frame_err", frame_err, 1);
    check_output("restart_qempty", exp_q.size(), 0);
    pulse_clr();
    check_output("restart_clr", frame_err, 0);

    // Reset while shifting with two words queued.
    out_ready = 1'b0;
    start_frame(4'd3);
    apply_stimulus(24'h0F0F0F, 24, 3'd1, 1'b0);
    apply_stimulus(24'hF0F0F0, 24, 3'd6, 1'b0);
    apply_stimulus(24'hAAAAAA, 5, 3'd5, 1'b0);
    check_output("midrst_before_valid", out_valid, 1);
    reset = 1'b1;
    tick();
    check_output("midrst_valid", out_valid, 0);
    check_output("midrst_busy", busy, 0);
    reset = 1'b0;
    exp_q.delete();

    // Zero-word frame.
    out_ready = 1'b1;
    seen_done = 1'b0;
    pushes = 0;
    start_frame(4'd0);
    for (int c = 0; c < 4; c++) begin
      if (frame_done) seen_done = 1'b1;
      if (word_done || out_valid) pushes++;
      if (c == 0) check_output("zero_busy", busy, 0);
      tick();
    end
    check_output("zero_frame_done", seen_done, 1);
    check_output("zero_no_push", pushes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
